// File: rtl/slide_puzzle_pkg.sv
// Shared definitions for the sliding-tile puzzle: game status codes, blank-move
// directions, FSM states and board geometry helpers.
package slide_puzzle_pkg;

  localparam logic [1:0] ST_CHOSE_BOARD  = 2'b00;
  localparam logic [1:0] ST_GAMING       = 2'b01;
  localparam logic [1:0] ST_GAME_INITIAL = 2'b10;
  localparam logic [1:0] ST_WINNED       = 2'b11;

  // Direction codes match the act bit positions.
  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  localparam int MAX_BOARD_BITS = 1024;

  typedef enum logic {IDLE, SHUFFLE} state_t;

  // Solved board packed like board_out (cell 0 in the top bits); upper bits zero.
  function automatic logic [MAX_BOARD_BITS-1:0] solved_board(input int rows, input int cols,
                                                              input int tw);
    logic [MAX_BOARD_BITS-1:0] b;
    int n;
    b = '0;
    n = rows * cols;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < tw; j++)
        b[(n-1-i)*tw + j] = i[j];
    return b;
  endfunction

  function automatic logic legal_move(input int pos, input logic [1:0] dir, input int rows,
                                      input int cols);
    logic ok;
    ok = 1'b0;
    case (dir)
      DIR_UP:    ok = (pos / cols) > 0;
      DIR_RIGHT: ok = (pos % cols) < cols - 1;
      DIR_DOWN:  ok = (pos / cols) < rows - 1;
      default:   ok = (pos % cols) > 0;
    endcase
    return ok;
  endfunction

  // Cell the blank would move into; only meaningful when legal_move holds.
  function automatic int neighbour(input int pos, input logic [1:0] dir, input int cols);
    int nb;
    case (dir)
      DIR_UP:    nb = pos - cols;
      DIR_RIGHT: nb = pos + 1;
      DIR_DOWN:  nb = pos + cols;
      default:   nb = pos - 1;
    endcase
    return nb;
  endfunction

endpackage

// File: rtl/slide_puzzle_core_lfsr.sv
// 16-bit Galois LFSR (x^16+x^14+x^13+x^11) advancing every cycle; exposes the
// two low bits used as the shuffle candidate direction.
module puzzle_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic       clk_d,
  input  logic       rst,
  output logic [1:0] dir_bits
);

  logic [15:0] lfsr_reg;

  always_ff @(posedge clk_d or posedge rst) begin
    if (rst) lfsr_reg <= SEED;
    else     lfsr_reg <= {1'b0, lfsr_reg[15:1]} ^ (lfsr_reg[0] ? 16'hB400 : 16'h0000);
  end

  assign dir_bits = lfsr_reg[1:0];

endmodule

// File: rtl/slide_puzzle_core.sv
// Sliding-tile puzzle engine: board load, random-walk shuffle, player moves with
// edge checking, saturating move counter and registered win detection.
module slide_puzzle_core
  import slide_puzzle_pkg::*;
#(
  parameter int          ROWS          = 2,
  parameter int          COLS          = 2,
  parameter int          TW            = $clog2(ROWS*COLS),
  parameter int          SHUFFLE_MOVES = 16,
  parameter int          CNT_W         = 10,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                          clk_d,
  input  logic                          rst,
  input  logic [1:0]                    game_status,
  input  logic [3:0]                    act,
  input  logic                          load,
  input  logic [ROWS*COLS*TW-1:0]       load_board,
  input  logic                          shuffle_req,
  output logic [ROWS*COLS*TW-1:0]       board_out,
  output logic [$clog2(ROWS*COLS)-1:0]  blank_pos,
  output logic [CNT_W-1:0]              move_cnt,
  output logic                          busy,
  output logic                          win_flag
);

  localparam int N  = ROWS * COLS;
  localparam int PW = $clog2(N);
  localparam int WW = $clog2(SHUFFLE_MOVES + 1);
  localparam logic [MAX_BOARD_BITS-1:0] SOLVED_WIDE = solved_board(ROWS, COLS, TW);
  localparam logic [N*TW-1:0]           SOLVED      = SOLVED_WIDE[N*TW-1:0];

  state_t          state_reg, state_next;
  logic [TW-1:0]   board_reg [N];
  logic [TW-1:0]   board_next [N];
  logic [TW-1:0]   solved_tiles [N];
  logic [TW-1:0]   load_tiles [N];
  logic [PW-1:0]   blank_reg, blank_next, load_blank, nb_pos;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [WW-1:0]   walk_reg, walk_next;
  logic [1:0]      prev_reg, prev_next;
  logic            prev_valid_reg, prev_valid_next;
  logic            win_reg;
  logic [1:0]      dir_bits, cand, shuf_dir, act_dir, sw_dir;
  logic            shuf_found, sw_en;

  puzzle_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk_d    (clk_d),
    .rst      (rst),
    .dir_bits (dir_bits)
  );

  for (genvar gi = 0; gi < N; gi++) begin : g_cells
    assign solved_tiles[gi] = SOLVED[(N-1-gi)*TW +: TW];
    assign load_tiles[gi]   = load_board[(N-1-gi)*TW +: TW];
    assign board_out[(N-1-gi)*TW +: TW] = board_reg[gi];
  end

  always_comb begin
    load_blank = '0;
    for (int i = 0; i < N; i++)
      if (load_tiles[i] == TW'(N - 1)) load_blank = PW'(i);
  end

  // Rotate from the LFSR candidate until the move is on-board and not an undo.
  always_comb begin
    shuf_dir   = dir_bits;
    shuf_found = 1'b0;
    cand       = dir_bits;
    for (int k = 0; k < 4; k++) begin
      cand = dir_bits + 2'(k);
      if (!shuf_found && legal_move(int'(blank_reg), cand, ROWS, COLS) &&
          !(prev_valid_reg && cand == (prev_reg ^ 2'b10))) begin
        shuf_found = 1'b1;
        shuf_dir   = cand;
      end
    end
  end

  always_comb begin
    if      (act[0]) act_dir = DIR_UP;
    else if (act[1]) act_dir = DIR_RIGHT;
    else if (act[2]) act_dir = DIR_DOWN;
    else             act_dir = DIR_LEFT;
  end

  always_comb begin
    state_next      = state_reg;
    board_next      = board_reg;
    blank_next      = blank_reg;
    cnt_next        = cnt_reg;
    walk_next       = walk_reg;
    prev_next       = prev_reg;
    prev_valid_next = prev_valid_reg;
    sw_en           = 1'b0;
    sw_dir          = act_dir;
    nb_pos          = blank_reg;
    case (state_reg)
      IDLE: begin
        if (game_status == ST_CHOSE_BOARD && load) begin
          board_next = load_tiles;
          blank_next = load_blank;
        end else if (game_status == ST_CHOSE_BOARD && shuffle_req) begin
          state_next      = SHUFFLE;
          board_next      = solved_tiles;
          blank_next      = PW'(N - 1);
          walk_next       = WW'(SHUFFLE_MOVES);
          prev_valid_next = 1'b0;
        end else if (game_status == ST_GAMING && (|act) &&
                     legal_move(int'(blank_reg), act_dir, ROWS, COLS)) begin
          sw_en    = 1'b1;
          cnt_next = (&cnt_reg) ? cnt_reg : cnt_reg + 1'b1;
        end
      end
      SHUFFLE: begin
        sw_en           = 1'b1;
        sw_dir          = shuf_dir;
        prev_next       = shuf_dir;
        prev_valid_next = 1'b1;
        walk_next       = walk_reg - 1'b1;
        if (walk_reg == WW'(1)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (game_status == ST_GAME_INITIAL) cnt_next = '0;
    if (sw_en) begin
      nb_pos                = PW'(neighbour(int'(blank_reg), sw_dir, COLS));
      board_next[blank_reg] = board_reg[nb_pos];
      board_next[nb_pos]    = board_reg[blank_reg];
      blank_next            = nb_pos;
    end
  end

  always_ff @(posedge clk_d or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      for (int i = 0; i < N; i++) board_reg[i] <= solved_tiles[i];
      blank_reg      <= PW'(N - 1);
      cnt_reg        <= '0;
      walk_reg       <= '0;
      prev_reg       <= DIR_UP;
      prev_valid_reg <= 1'b0;
      win_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      board_reg      <= board_next;
      blank_reg      <= blank_next;
      cnt_reg        <= cnt_next;
      walk_reg       <= walk_next;
      prev_reg       <= prev_next;
      prev_valid_reg <= prev_valid_next;
      win_reg        <= (board_out == SOLVED) &&
                        (game_status == ST_GAMING || game_status == ST_WINNED);
    end
  end

  assign blank_pos = blank_reg;
  assign move_cnt  = cnt_reg;
  assign busy      = (state_reg == SHUFFLE);
  assign win_flag  = win_reg;

endmodule
